program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 159 +++++++++++++++
 tb/tb_program_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// UART program loader: receives a length-prefixed word stream and writes it
// into IMEM or DMEM, then replies with an XOR checksum or an error byte.
module program_loader #(
    parameter int MAX_WORDS = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        grant_i,
    input  logic        target_i,
    input  logic [7:0]  uart_rx_data_i,
    input  logic        uart_rx_ready_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_start_o,
    input  logic        tx_done_i,
    output logic        imem_we_o,
    output logic        dmem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        done_o
);

    typedef enum logic [3:0] {
        IDLE, LEN_LO, LEN_HI, CHECK, RX_DATA,
        WRITE, SEND, WAIT_TX, FINISH
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    state_t      state_q, state_d;
    logic        target_q, target_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [7:0]  csum_q, csum_d;
    logic [7:0]  tx_q, tx_d;
    logic [31:0] word_q, word_d;
    logic        fin_q;
    logic        too_long;
    logic        abort;

    assign too_long = {1'b0, len_q} > MAX_LEN;
    // Losing the grant mid-session drops everything; FINISH owns its own exit.
    assign abort = !grant_i && state_q != IDLE && state_q != FINISH;

    assign tx_data_o   = tx_q;
    assign mem_addr_o  = {14'd0, idx_q, 2'b00};
    assign mem_wdata_o = word_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            target_q <= 1'b0;
            len_q    <= '0;
            idx_q    <= '0;
            bcnt_q   <= '0;
            csum_q   <= '0;
            tx_q     <= '0;
            word_q   <= '0;
            fin_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            bcnt_q   <= bcnt_d;
            csum_q   <= csum_d;
            tx_q     <= tx_d;
            word_q   <= word_d;
            fin_q    <= (state_q == FINISH);
        end
    end

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        len_d      = len_q;
        idx_d      = idx_q;
        bcnt_d     = bcnt_q;
        csum_d     = csum_q;
        tx_d       = tx_q;
        word_d     = word_q;
        imem_we_o  = 1'b0;
        dmem_we_o  = 1'b0;
        tx_start_o = 1'b0;
        done_o     = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant_i) begin
                        state_d  = LEN_LO;
                        target_d = target_i;
                        idx_d    = '0;
                        bcnt_d   = '0;
                        csum_d   = '0;
                    end
                end
                LEN_LO: begin
                    if (uart_rx_ready_i) begin
                        len_d[7:0] = uart_rx_data_i;
                        state_d    = LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (uart_rx_ready_i) begin
                        len_d[15:8] = uart_rx_data_i;
                        state_d     = CHECK;
                    end
                end
                CHECK: begin
                    unique case (1'b1)
                        too_long: begin
                            tx_d    = 8'hEE;
                            state_d = SEND;
                        end
                        (len_q == 16'd0): begin
                            tx_d    = 8'h00;
                            state_d = SEND;
                        end
                        default: state_d = RX_DATA;
                    endcase
                end
                RX_DATA: begin
                    if (uart_rx_ready_i) begin
                        word_d[{bcnt_q, 3'b000} +: 8] = uart_rx_data_i;
                        csum_d = csum_q ^ uart_rx_data_i;
                        bcnt_d = bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) state_d = WRITE;
                    end
                end
                WRITE: begin
                    imem_we_o = !target_q;
                    dmem_we_o = target_q;
                    idx_d     = idx_q + 16'd1;
                    if (idx_d == len_q) begin
                        tx_d    = csum_q;
                        state_d = SEND;
                    end else begin
                        state_d = RX_DATA;
                    end
                end
                SEND: begin
                    tx_start_o = 1'b1;
                    state_d    = WAIT_TX;
                end
                WAIT_TX: begin
                    if (tx_done_i) state_d = FINISH;
                end
                FINISH: begin
                    done_o = !fin_q;
                    if (!grant_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: stimulus streams are scored against
// a reference that derives writes and reply bytes from the byte stream alone.
module tb_program_loader;

    localparam int MAXW = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        grant_i = 1'b0;
    logic        target_i = 1'b0;
    logic [7:0]  uart_rx_data_i = 8'h00;
    logic        uart_rx_ready_i = 1'b0;
    logic        tx_done_i = 1'b0;
    logic [7:0]  tx_data_o;
    logic        tx_start_o;
    logic        imem_we_o;
    logic        dmem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        done_o;

    program_loader #(.MAX_WORDS(MAXW)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .grant_i         (grant_i),
        .target_i        (target_i),
        .uart_rx_data_i  (uart_rx_data_i),
        .uart_rx_ready_i (uart_rx_ready_i),
        .tx_data_o       (tx_data_o),
        .tx_start_o      (tx_start_o),
        .tx_done_i       (tx_done_i),
        .imem_we_o       (imem_we_o),
        .dmem_we_o       (dmem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .done_o          (done_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [95:0] got,
                         input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observed DUT activity
    logic [64:0] wr_q[$];
    int          tx_cnt = 0;
    int          done_cnt = 0;
    int          both_cnt = 0;
    logic [7:0]  tx_seen = 8'h00;

    always @(negedge clk_i) begin
        if (imem_we_o && dmem_we_o) both_cnt++;
        if (imem_we_o) wr_q.push_back({1'b0, mem_addr_o, mem_wdata_o});
        if (dmem_we_o) wr_q.push_back({1'b1, mem_addr_o, mem_wdata_o});
        if (tx_start_o) begin
            tx_cnt++;
            tx_seen = tx_data_o;
        end
        if (done_o) done_cnt++;
    end

    // Stimulus stream and expectations
    logic [7:0]  stim[$];
    logic [64:0] exp_w[$];
    logic [7:0]  exp_tx;

    function automatic void model(input bit tgt);
        int          n;
        logic [7:0]  cs;
        logic [31:0] w;
        exp_w.delete();
        n = int'({stim[1], stim[0]});
        if (n > MAXW) begin
            exp_tx = 8'hEE;
            return;
        end
        cs = 8'h00;
        for (int i = 0; i < n; i++) begin
            w = {stim[2+4*i+3], stim[2+4*i+2], stim[2+4*i+1], stim[2+4*i]};
            cs ^= w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
            exp_w.push_back({tgt, 32'(4 * i), w});
        end
        exp_tx = cs;
    endfunction

    task automatic gen(input int n);
        logic [15:0] ln;
        ln = n[15:0];
        stim.delete();
        stim.push_back(ln[7:0]);
        stim.push_back(ln[15:8]);
        if (n <= MAXW)
            for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom));
    endtask

    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(3, 7)) @(posedge clk_i);
        #1;
        uart_rx_data_i  = b;
        uart_rx_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        uart_rx_ready_i = 1'b0;
        uart_rx_data_i  = 8'($urandom);
    endtask

    task automatic pulse_tx_done();
        @(posedge clk_i);
        #1 tx_done_i = 1'b1;
        @(posedge clk_i);
        #1 tx_done_i = 1'b0;
    endtask

    task automatic wait_tx(input int t0);
        for (int k = 0; k < 100 && tx_cnt == t0; k++) @(posedge clk_i);
        #1;
        if (tx_cnt == t0) check("tx_timeout", 0, 1);
    endtask

    task automatic run_session(input bit tgt);
        int t0, d0;
        model(tgt);
        wr_q.delete();
        t0 = tx_cnt;
        d0 = done_cnt;
        @(posedge clk_i);
        #1;
        grant_i  = 1'b1;
        target_i = tgt;
        foreach (stim[i]) begin
            send_byte(stim[i]);
            target_i = ~tgt;
        end
        wait_tx(t0);
        check("tx_start_cnt", tx_cnt - t0, 1);
        check("tx_data", tx_seen, exp_tx);
        repeat ($urandom_range(1, 5)) @(posedge clk_i);
        #1 check("tx_hold", tx_data_o, exp_tx);
        check("done_early", done_cnt - d0, 0);
        pulse_tx_done();
        for (int k = 0; k < 20 && done_cnt == d0; k++) @(posedge clk_i);
        repeat (3) @(posedge clk_i);
        #1 check("done_cnt", done_cnt - d0, 1);
        grant_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("wr_count", wr_q.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < wr_q.size(); i++)
            check($sformatf("wr%0d", i), wr_q[i], exp_w[i]);
        check("both_we", both_cnt, 0);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_imem"}, imem_we_o, 0);
        check({pfx, "_dmem"}, dmem_we_o, 0);
        check({pfx, "_txs"}, tx_start_o, 0);
        check({pfx, "_done"}, done_o, 0);
        check({pfx, "_txd"}, tx_data_o, 0);
        check({pfx, "_addr"}, mem_addr_o, 0);
        check({pfx, "_wdata"}, mem_wdata_o, 0);
    endtask

    initial begin
        #2 rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 check_outputs_zero("rst");
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);

        // Two-word IMEM load
        stim = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_session(1'b0);
        // One-word DMEM load, zero checksum
        stim = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_session(1'b1);
        check("dm_csum", tx_seen, 8'h00);
        // Oversized and empty lengths
        stim = '{8'hFF, 8'hFF};
        run_session(1'b0);
        check("ff_reply", tx_seen, 8'hEE);
        stim = '{8'h00, 8'h00};
        run_session(1'b1);
        gen(MAXW);
        run_session(1'b1);
        gen(MAXW + 1);
        run_session(1'b0);

        // Abort after two payload bytes
        begin
            int t0, d0;
            wr_q.delete();
            t0 = tx_cnt;
            d0 = done_cnt;
            @(posedge clk_i);
            #1 grant_i = 1'b1;
            target_i = 1'b0;
            send_byte(8'h02);
            send_byte(8'h00);
            send_byte(8'h11);
            send_byte(8'h22);
            @(posedge clk_i);
            #1 grant_i = 1'b0;
            send_byte(8'h33);
            send_byte(8'h44);
            repeat (20) @(posedge clk_i);
            #1;
            check("abort_wr", wr_q.size(), 0);
            check("abort_tx", tx_cnt - t0, 0);
            check("abort_done", done_cnt - d0, 0);
        end
        stim = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_session(1'b0);

        // Reset while waiting for the reply to go out
        begin
            int t0, d0;
            gen(2);
            wr_q.delete();
            t0 = tx_cnt;
            @(posedge clk_i);
            #1 grant_i = 1'b1;
            target_i = 1'b1;
            foreach (stim[i]) send_byte(stim[i]);
            wait_tx(t0);
            check("rstw_wr", wr_q.size(), 2);
            repeat (2) @(posedge clk_i);
            #3 rst_ni = 1'b0;
            #1 check_outputs_zero("rstw");
            grant_i = 1'b0;
            repeat (2) @(posedge clk_i);
            #1 rst_ni = 1'b1;
            t0 = tx_cnt;
            d0 = done_cnt;
            pulse_tx_done();
            repeat (10) @(posedge clk_i);
            #1;
            check("rstw_done", done_cnt - d0, 0);
            check("rstw_tx", tx_cnt - t0, 0);
        end

        // Random sessions
        for (int s = 0; s < 12; s++) begin
            int n;
            n = ($urandom_range(0, 9) == 0) ? 65535 : int'($urandom_range(0, MAXW + 2));
            gen(n);
            run_session(1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
